// File: rtl/fwd_arb_sched.sv
// Round-robin scheduler for the forwarding arbiter.
// Grants the shared forwarder to one requesting packet-filter core, drives the
// select of the registered mux tree, waits out the mux-tree latency, starts the
// forwarder and acknowledges the granted core once forwarding completes.
// Every output comes straight from a flop.

module fwd_arb_sched #(
    parameter int unsigned N_CORES   = 4,
    parameter int unsigned SEL_WIDTH = 2,
    parameter int unsigned MUX_LAT   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_CORES-1:0]   req_i,
    input  logic                 fwd_ready_i,
    input  logic                 fwd_done_i,
    output logic [N_CORES-1:0]   gnt_o,
    output logic [SEL_WIDTH-1:0] sel_o,
    output logic                 sel_valid_o,
    output logic                 fwd_start_o,
    output logic [N_CORES-1:0]   core_ack_o
);

    // Settle counter only has to hold MUX_LAT-1.
    localparam int unsigned CntW = (MUX_LAT > 1) ? $clog2(MUX_LAT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StBusy
    } state_e;

    state_e               state_q, state_d;
    logic [N_CORES-1:0]   gnt_q, gnt_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 sel_valid_q, sel_valid_d;
    logic                 fwd_start_q, fwd_start_d;
    logic [N_CORES-1:0]   core_ack_q, core_ack_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;

    logic [N_CORES-1:0]   req_eff;
    logic                 pick_found;
    logic [SEL_WIDTH-1:0] pick_idx;
    logic [SEL_WIDTH-1:0] cand;
    logic [SEL_WIDTH-1:0] ptr_after_sel;

    // (base + off) mod N_CORES; off is always < N_CORES so one subtraction is enough.
    function automatic logic [SEL_WIDTH-1:0] wrap_add(input logic [SEL_WIDTH-1:0] base,
                                                       input int unsigned        off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_CORES) begin
            s = s - N_CORES;
        end
        return SEL_WIDTH'(s);
    endfunction

    // A core being acked this cycle may still hold req; do not re-grant it.
    assign req_eff = req_i & ~core_ack_q;

    // Round-robin pick: first eligible request at or above the pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            cand = wrap_add(ptr_q, i);
            if (!pick_found && req_eff[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Pointer advances past the core just served.
    assign ptr_after_sel = wrap_add(sel_q, 1);

    // Next-state and registered-output logic for the grant FSM.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        fwd_start_d = 1'b0;
        core_ack_d  = '0;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;

        unique case (state_q)
            StIdle: begin
                if (fwd_ready_i && pick_found) begin
                    gnt_d       = N_CORES'(1) << pick_idx;
                    sel_d       = pick_idx;
                    sel_valid_d = 1'b1;
                    cnt_d       = CntW'(MUX_LAT - 1);
                    state_d     = StSettle;
                end
            end
            StSettle: begin
                // fwd_start lands MUX_LAT cycles after gnt first shows.
                if (cnt_q == '0) begin
                    fwd_start_d = 1'b1;
                    state_d     = StBusy;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StBusy: begin
                if (fwd_done_i) begin
                    core_ack_d  = gnt_q;
                    gnt_d       = '0;
                    sel_valid_d = 1'b0;
                    ptr_d       = ptr_after_sel;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                gnt_d       = '0;
                sel_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any grant without an ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            fwd_start_q <= 1'b0;
            core_ack_q  <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            fwd_start_q <= fwd_start_d;
            core_ack_q  <= core_ack_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign sel_o       = sel_q;
    assign sel_valid_o = sel_valid_q;
    assign fwd_start_o = fwd_start_q;
    assign core_ack_o  = core_ack_q;

`ifndef SYNTHESIS
    // Grant stays one-hot and sel_valid mirrors a live grant.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert ($onehot0(gnt_q));
            assert (sel_valid_q == (|gnt_q));
        end
    end
`endif

endmodule

// File: tb/tb_fwd_arb_sched.sv
// Directed bench for fwd_arb_sched (N_CORES=4, MUX_LAT=2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_fwd_arb_sched;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       fwd_ready;
    logic       fwd_done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       sel_valid;
    logic       fwd_start;
    logic [3:0] core_ack;

    int checks = 0;
    int errors = 0;

    fwd_arb_sched #(
        .N_CORES  (N),
        .SEL_WIDTH(2),
        .MUX_LAT  (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .fwd_ready_i(fwd_ready),
        .fwd_done_i (fwd_done),
        .gnt_o      (gnt),
        .sel_o      (sel),
        .sel_valid_o(sel_valid),
        .fwd_start_o(fwd_start),
        .core_ack_o (core_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; fwd_ready = 1'b0; fwd_done = 1'b0;
        step();
        step();
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_grant got gnt=%b sel=%0d sv=%b want 0000/0/0", gnt, sel, sel_valid);
        end
        checks++;
        if (fwd_start !== 1'b0 || core_ack !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses got fs=%b ack=%b want 0/0000", fwd_start, core_ack);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req = 4'b0100; fwd_ready = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || sel_valid !== 1'b1 || fwd_start !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt got gnt=%b sel=%0d sv=%b fs=%b want 0100/2/1/0",
                     gnt, sel, sel_valid, fwd_start);
        end
        step();
        checks++;
        if (fwd_start !== 1'b0) begin
            errors++;
            $display("FAIL single_fs_early got %b want 0", fwd_start);
        end
        step();
        checks++;
        if (fwd_start !== 1'b1 || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL single_fs got fs=%b gnt=%b want 1/0100", fwd_start, gnt);
        end
        step();
        checks++;
        if (fwd_start !== 1'b0) begin
            errors++;
            $display("FAIL single_fs_once got %b want 0", fwd_start);
        end
        fwd_done = 1'b1;
        step();
        checks++;
        if (core_ack !== 4'b0100 || gnt !== 4'b0000 || sel_valid !== 1'b0 || sel !== 2'd2) begin
            errors++;
            $display("FAIL single_ack got ack=%b gnt=%b sv=%b sel=%0d want 0100/0000/0/2",
                     core_ack, gnt, sel_valid, sel);
        end
        fwd_done = 1'b0; req = '0;
        step();
        checks++;
        if (core_ack !== 4'b0000 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_ack_pulse got ack=%b gnt=%b want 0000/0000", core_ack, gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        rst = 1'b1;
        step();
        rst = 1'b0; req = 4'b1111; fwd_ready = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            checks++;
            if (gnt !== exp || sel !== 2'(k % 4)) begin
                errors++;
                $display("FAIL rr_gnt%0d got gnt=%b sel=%0d want %b/%0d", k, gnt, sel, exp, k % 4);
            end
            step();
            step();
            checks++;
            if (fwd_start !== 1'b1) begin
                errors++;
                $display("FAIL rr_fs%0d got %b want 1", k, fwd_start);
            end
            step();
            step();
            step();
            fwd_done = 1'b1;
            step();
            fwd_done = 1'b0;
            checks++;
            if (core_ack !== exp || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL rr_ack%0d got ack=%b gnt=%b want %b/0000", k, core_ack, gnt, exp);
            end
            if (k == 4) req = '0;
            step();
        end
    endtask

    task automatic test_hold_during_ack();
        req = 4'b0001;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL hold_gnt got %b want 0001", gnt);
        end
        step();
        step();
        fwd_done = 1'b1;
        step();
        fwd_done = 1'b0;
        checks++;
        if (core_ack !== 4'b0001) begin
            errors++;
            $display("FAIL hold_ack got %b want 0001", core_ack);
        end
        // req still held through the ack cycle
        step();
        checks++;
        if (gnt !== 4'b0000 || sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_regrant got gnt=%b sv=%b want 0000/0", gnt, sel_valid);
        end
        req = '0;
        step();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL hold_idle got %b want 0000", gnt);
        end
        req = 4'b0001;
        step();
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            errors++;
            $display("FAIL hold_regrant got gnt=%b sel=%0d want 0001/0", gnt, sel);
        end
        step();
        step();
        fwd_done = 1'b1; req = '0;
        step();
        fwd_done = 1'b0;
        step();
    endtask

    task automatic test_fwd_ready();
        fwd_ready = 1'b0; req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL ready_block%0d got %b want 0000", i, gnt);
            end
        end
        fwd_ready = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            errors++;
            $display("FAIL ready_gnt got gnt=%b sel=%0d want 0010/1", gnt, sel);
        end
        step();
        step();
        fwd_done = 1'b1; req = '0;
        step();
        fwd_done = 1'b0;
        checks++;
        if (core_ack !== 4'b0010) begin
            errors++;
            $display("FAIL ready_ack got %b want 0010", core_ack);
        end
        step();
    endtask

    task automatic test_reset_busy();
        // Pointer is at 2 here, so core 3 wins from 1000.
        req = 4'b1000;
        step();
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            errors++;
            $display("FAIL rstb_gnt got gnt=%b sel=%0d want 1000/3", gnt, sel);
        end
        step();
        step();
        step();
        rst = 1'b1; fwd_done = 1'b1; req = 4'b1010;
        step();
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'd0 || sel_valid !== 1'b0 || fwd_start !== 1'b0 ||
            core_ack !== 4'b0000) begin
            errors++;
            $display("FAIL rstb_outputs got gnt=%b sel=%0d sv=%b fs=%b ack=%b want all zero",
                     gnt, sel, sel_valid, fwd_start, core_ack);
        end
        rst = 1'b0; fwd_done = 1'b0;
        step();
        // Pointer back at 0: core 1 wins over core 3.
        checks++;
        if (gnt !== 4'b0010 || core_ack !== 4'b0000) begin
            errors++;
            $display("FAIL rstb_ptr got gnt=%b ack=%b want 0010/0000", gnt, core_ack);
        end
        rst = 1'b1; req = 4'b1000;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            errors++;
            $display("FAIL rstb_regrant got gnt=%b sel=%0d want 1000/3", gnt, sel);
        end
        rst = 1'b1; req = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_ignored_inputs();
        fwd_done = 1'b1;
        step();
        fwd_done = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || core_ack !== 4'b0000 || sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL ign_idle got gnt=%b ack=%b sv=%b want 0000/0000/0",
                     gnt, core_ack, sel_valid);
        end
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL ign_gnt got %b want 0100", gnt);
        end
        fwd_done = 1'b1;
        step();
        fwd_done = 1'b0;
        checks++;
        if (core_ack !== 4'b0000 || gnt !== 4'b0100 || fwd_start !== 1'b0) begin
            errors++;
            $display("FAIL ign_settle got ack=%b gnt=%b fs=%b want 0000/0100/0",
                     core_ack, gnt, fwd_start);
        end
        step();
        checks++;
        if (fwd_start !== 1'b1) begin
            errors++;
            $display("FAIL ign_fs got %b want 1", fwd_start);
        end
        req = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (gnt !== 4'b0100 || sel_valid !== 1'b1 || fwd_start !== 1'b0) begin
                errors++;
                $display("FAIL ign_hold%0d got gnt=%b sv=%b fs=%b want 0100/1/0",
                         i, gnt, sel_valid, fwd_start);
            end
        end
        fwd_done = 1'b1;
        step();
        fwd_done = 1'b0;
        checks++;
        if (core_ack !== 4'b0100 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL ign_ack got ack=%b gnt=%b want 0100/0000", core_ack, gnt);
        end
        step();
        checks++;
        if (core_ack !== 4'b0000 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL ign_end got ack=%b gnt=%b want 0000/0000", core_ack, gnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold_during_ack();
        test_fwd_ready();
        test_reset_busy();
        test_ignored_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got still running want finished");
        $fatal(1);
    end

endmodule
